// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions for the hazard controller: FSM state encoding,
// the hardwired zero register number, the default memory-wait timeout and
// the bundle of pipeline control outputs the controller produces.
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  // Controller states. Encoding 3 is never entered on purpose; if it ever
  // appears the FSM falls back to RUN on the next edge.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } hz_state_e;

  // Register 0 is hardwired to zero, so a load targeting it never creates
  // a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default number of MEM_WAIT cycles tolerated before giving up.
  localparam int DEFAULT_MEM_TIMEOUT = 255;

  // Width of the internal memory-wait cycle counter.
  localparam int WAIT_CNT_W = 8;

  // All hold/bubble/flush outputs grouped so they can be defaulted and
  // gated as a single value.
  typedef struct packed {
    logic pcHold;
    logic ifidHold;
    logic idexHold;
    logic exmemHold;
    logic idexBubble;
    logic ifidFlush;
  } hz_ctrl_t;

  // A memory miss is an access issued this cycle that did not complete.
  function automatic logic isMemMiss(input logic req, input logic ready);
    return req && !ready;
  endfunction

endpackage

// File: rtl/hazard_ctrl_loaduse.sv
// ---------------------------------------------------------------------------
// loaduse_detect
// Purely combinational load-use comparator. Flags when the load in EX
// writes a register that the instruction in ID is about to read.
// Ports:
//   exMemRead_i  - EX instruction is a load
//   exRt_i       - destination register of that load
//   idRs_i       - rs source of the ID instruction
//   idRt_i       - rt field of the ID instruction
//   idUsesRt_i   - ID instruction actually reads rt
//   loadUse_o    - load-use hazard present
// ---------------------------------------------------------------------------
module loaduse_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       exMemRead_i,
  input  logic [4:0] exRt_i,
  input  logic [4:0] idRs_i,
  input  logic [4:0] idRt_i,
  input  logic       idUsesRt_i,
  output logic       loadUse_o
);

  // rt only counts as a source when the ID instruction really reads it;
  // writes to register 0 are discarded so they never cause a stall.
  assign loadUse_o = exMemRead_i && (exRt_i != REG_ZERO) &&
                     ((exRt_i == idRs_i) || (idUsesRt_i && (exRt_i == idRt_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller. Arbitrates between a taken branch (flush),
// a data-memory miss (freeze the pipe until the memory answers or times
// out) and a load-use dependency (one-cycle bubble). Also keeps a sticky
// memory-timeout error flag and a saturating count of stall cycles.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   id_rs, id_rt,
//   id_uses_rt            - source registers of the instruction in ID
//   ex_memread, ex_rt     - load in EX and its destination register
//   branch_taken          - branch resolved taken in EX
//   mem_req, mem_ready    - MEM-stage access handshake
//   pc_hold, ifid_hold,
//   idex_hold, exmem_hold - pipeline register freezes
//   idex_bubble           - zero the control fields entering ID/EX
//   ifid_flush            - replace IF/ID contents with a NOP
//   mem_err               - sticky memory timeout flag
//   stall_cnt             - saturating stall/bubble/flush cycle count
//   state                 - current FSM state (debug)
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  // Wait-counter value seen on the last tolerated MEM_WAIT cycle: the
  // counter starts at 0 on entry, so the MEM_TIMEOUT-th cycle reads
  // MEM_TIMEOUT-1.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic                  memErr_q, memErr_d;
  logic [CNT_W-1:0]      stallCnt_q, stallCnt_d;
  hz_ctrl_t              ctrl;
  logic                  loadUse;
  logic                  stallEvent;

  loaduse_detect u_loaduse (
    .exMemRead_i (ex_memread),
    .exRt_i      (ex_rt),
    .idRs_i      (id_rs),
    .idRt_i      (id_rt),
    .idUsesRt_i  (id_uses_rt),
    .loadUse_o   (loadUse)
  );

  // State, wait counter, error flag and stall counter all clear the
  // instant reset drops, which also aborts any wait or flush in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Next-state and Mealy control outputs. In RUN the events are taken in
  // priority order branch > memory miss > load-use. A miss raises no hold
  // in the cycle it is detected; the freeze starts in MEM_WAIT. Inside
  // MEM_WAIT only mem_ready matters, and a ready response wins over a
  // timeout landing in the same cycle. Reset forces every control output
  // low even though the state is already RUN, because RUN's outputs are
  // input-dependent.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;
    ctrl      = '0;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          ctrl.ifidFlush  = 1'b1;
          ctrl.idexBubble = 1'b1;
          state_d         = FLUSH;
        end else if (isMemMiss(mem_req, mem_ready)) begin
          waitCnt_d = '0;
          state_d   = MEM_WAIT;
        end else if (loadUse) begin
          ctrl.pcHold     = 1'b1;
          ctrl.ifidHold   = 1'b1;
          ctrl.idexBubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        ctrl.pcHold    = 1'b1;
        ctrl.ifidHold  = 1'b1;
        ctrl.idexHold  = 1'b1;
        ctrl.exmemHold = 1'b1;
        waitCnt_d      = waitCnt_q + 1'b1;
        if (mem_ready) begin
          state_d = RUN;
        end else if (waitCnt_q == WAIT_LAST) begin
          memErr_d = 1'b1;
          state_d  = RUN;
        end
      end

      FLUSH: begin
        ctrl.ifidFlush = 1'b1;
        state_d        = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (!reset) begin
      ctrl = '0;
    end
  end

  // Any cycle that freezes the PC, injects a bubble or flushes IF/ID costs
  // the pipeline a slot; the counter sticks at all-ones instead of wrapping.
  always_comb begin
    stallEvent = ctrl.pcHold || ctrl.idexBubble || ctrl.ifidFlush;
    stallCnt_d = stallCnt_q;
    if (stallEvent && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc_hold     = ctrl.pcHold;
  assign ifid_hold   = ctrl.ifidHold;
  assign idex_hold   = ctrl.idexHold;
  assign exmem_hold  = ctrl.exmemHold;
  assign idex_bubble = ctrl.idexBubble;
  assign ifid_flush  = ctrl.ifidFlush;
  assign mem_err     = memErr_q;
  assign stall_cnt   = stallCnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Each stimulus step pushes the
// expected outputs from a behavioural model into a scoreboard queue; a
// separate monitor pops and compares on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TIMEOUT   = 4;
  localparam int CNT_W     = 6;
  localparam int STALL_MAX = 63;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready;
  logic             pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  typedef struct {
    logic [5:0] ctl;
    logic [1:0] st;
    logic       err;
    logic [5:0] stall;
    int         id;
  } exp_t;

  exp_t sbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   stepNo = 0;

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = flushing.
  int   mMode = 0;
  int   mWaitCycles = 0;
  bit   mErr = 0;
  int   mStall = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_hold    (idex_hold),
    .exmem_hold   (exmem_hold),
    .idex_bubble  (idex_bubble),
    .ifid_flush   (ifid_flush),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .state        (state)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check bumps the counters here.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One clock step: drive inputs just after the rising edge, record what
  // the outputs must look like this cycle, then advance the model to the
  // state it will be in after the next rising edge.
  task automatic applyStimulus(input logic rstn, input logic br, input logic mreq,
                               input logic mrdy, input logic memrd, input logic [4:0] exrt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic usesrt);
    exp_t e;
    bit   pc, ifh, idh, exh, bub, fl, lu;
    @(posedge clk);
    #1;
    reset        = rstn;
    branch_taken = br;
    mem_req      = mreq;
    mem_ready    = mrdy;
    ex_memread   = memrd;
    ex_rt        = exrt;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = usesrt;
    e.id = stepNo;
    stepNo++;
    {pc, ifh, idh, exh, bub, fl} = 6'b0;
    if (!rstn) begin
      mMode = 0; mWaitCycles = 0; mErr = 0; mStall = 0;
      e.ctl = '0; e.st = '0; e.err = 1'b0; e.stall = '0;
    end else begin
      e.st    = 2'(mMode);
      e.err   = mErr;
      e.stall = 6'(mStall);
      lu = memrd && (exrt != 0) && ((exrt == rs) || (usesrt && (exrt == rt)));
      if (mMode == 0) begin
        if (br) begin
          fl = 1; bub = 1; mMode = 2;
        end else if (mreq && !mrdy) begin
          mMode = 1; mWaitCycles = 0;
        end else if (lu) begin
          pc = 1; ifh = 1; bub = 1;
        end
      end else if (mMode == 1) begin
        pc = 1; ifh = 1; idh = 1; exh = 1;
        mWaitCycles++;
        if (mrdy) mMode = 0;
        else if (mWaitCycles >= TIMEOUT) begin
          mErr = 1; mMode = 0;
        end
      end else begin
        fl = 1; mMode = 0;
      end
      e.ctl = {pc, ifh, idh, exh, bub, fl};
      if ((pc || bub || fl) && mStall < STALL_MAX) mStall++;
    end
    sbQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: compares the oldest expected entry against the DUT outputs
  // on the falling edge, away from the edge that updates state.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput("ctl", e.id,
                  {26'd0, pc_hold, ifid_hold, idex_hold, exmem_hold, idex_bubble, ifid_flush},
                  {26'd0, e.ctl});
      checkOutput("state", e.id, {30'd0, state}, {30'd0, e.st});
      checkOutput("mem_err", e.id, {31'd0, mem_err}, {31'd0, e.err});
      checkOutput("stall_cnt", e.id, {26'd0, stall_cnt}, {26'd0, e.stall});
    end
  end

  // Directed scenarios first, then a randomized run.
  initial begin
    reset = 1'b0; branch_taken = 0; mem_req = 0; mem_ready = 0;
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;

    // Reset held with active inputs: everything must stay low.
    applyStimulus(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    applyStimulus(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);

    // Load-use on rs, then one idle cycle.
    applyStimulus(1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    idle();
    // Load-use on rt only when rt is a source.
    applyStimulus(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1);
    applyStimulus(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    // Zero destination never stalls.
    applyStimulus(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);

    // Memory miss, three non-ready wait cycles, then ready.
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (3) applyStimulus(1, 1, 1, 0, 1, 5'd3, 5'd3, 5'd3, 1);
    applyStimulus(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle();

    // Branch together with load-use and a miss; branch again during flush.
    applyStimulus(1, 1, 1, 0, 1, 5'd7, 5'd7, 5'd0, 0);
    applyStimulus(1, 1, 1, 0, 1, 5'd7, 5'd7, 5'd0, 0);
    idle();

    // Timeout: miss then the memory never answers.
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (TIMEOUT) applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (3) idle();

    // Reset in the middle of a wait must clear without a clock edge.
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    applyStimulus(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    applyStimulus(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle();

    // Back-to-back load-use long enough to saturate the stall counter.
    repeat (STALL_MAX + 8) applyStimulus(1, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0);
    idle();

    // Randomized traffic with small register numbers to provoke matches.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", stepNo, 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before the controller aborts the wait.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-005 id_rs  in  5  rs field of the instruction in ID.
REQ-006 id_rt  in  5  rt field of the instruction in ID.
REQ-007 id_uses_rt  in  1  the ID instruction reads rt as a source.
REQ-008 ex_memread  in  1  the instruction in EX is a load (MemReadEX).
REQ-009 ex_rt  in  5  destination rt of the load in EX (insrtEX).
REQ-010 branch_taken  in  1  a branch resolved taken in EX this cycle.
REQ-011 mem_req  in  1  data memory access issued by the MEM stage this cycle.
REQ-012 mem_ready  in  1  data memory has completed the access.
REQ-013 pc_hold  out  1  freezes the PC.
REQ-014 ifid_hold  out  1  freezes the IF/ID register.
REQ-015 idex_hold  out  1  drives the hold input of the ID/EX register.
REQ-016 exmem_hold  out  1  freezes the EX/MEM register.
REQ-017 idex_bubble  out  1  forces zero control signals (MemWrite, MemRead, MemtoReg, RegWrite) into ID/EX.
REQ-018 ifid_flush  out  1  replaces the IF/ID contents with a NOP.
REQ-019 mem_err  out  1  sticky flag: a memory wait timed out.
REQ-020 stall_cnt  out  CNT_W  saturating count of stall/bubble cycles.
REQ-021 state  out  2  current FSM state, for debug.

Function
REQ-022 The FSM SHALL have states RUN=0, MEM_WAIT=1 and FLUSH=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-023 Load-use hazard (lu) SHALL be defined as ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-024 Event priority in RUN SHALL be: branch_taken > memory miss (mem_req && !mem_ready) > lu.
REQ-025 In RUN with branch_taken, ifid_flush=1 and idex_bubble=1 in the same cycle (Mealy); next state is FLUSH.
REQ-026 FLUSH SHALL last exactly one cycle with ifid_flush=1 and all other control outputs 0, then go to RUN; branch_taken arriving while in FLUSH is ignored.
REQ-027 In RUN with a memory miss and no branch, next state is MEM_WAIT; no hold is asserted in the detecting cycle.
REQ-028 In MEM_WAIT, pc_hold, ifid_hold, idex_hold and exmem_hold SHALL all be 1, with idex_bubble=0.
REQ-029 MEM_WAIT SHALL exit to RUN on the first cycle with mem_ready=1; the holds remain asserted during that exit cycle.
REQ-030 An internal 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-031 When the wait counter reaches MEM_TIMEOUT without mem_ready, the FSM SHALL set mem_err=1 and go to RUN.
REQ-032 mem_err SHALL stay set until reset.
REQ-033 In RUN with lu and no higher-priority event, pc_hold=1, ifid_hold=1 and idex_bubble=1 in the same cycle, idex_hold=0, and the state stays RUN.
REQ-034 The bubble of REQ-033 is exactly one cycle, because the load has advanced to MEM by the next cycle.
REQ-035 Inputs SHALL be ignored while in MEM_WAIT, except mem_ready.
REQ-036 stall_cnt SHALL increment by 1 on each edge where any of pc_hold, idex_bubble or ifid_flush is 1.
REQ-037 stall_cnt SHALL saturate at all-ones.
REQ-038 All outputs other than stall_cnt, state and mem_err SHALL be combinational from the state and the current inputs.

Reset
REQ-039 While reset=0 the block SHALL hold: state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
REQ-040 While reset=0 all hold, bubble and flush outputs SHALL be 0, regardless of the other inputs.
REQ-041 Reset asserted in MEM_WAIT or FLUSH SHALL abort the operation immediately.
REQ-042 The first edge after reset release SHALL evaluate inputs in RUN.

Structure
REQ-043 The state encodings, REG_ZERO=5'd0 and the default MEM_TIMEOUT SHALL live in the shared pipeline package.
REQ-044 The lu comparator SHALL be one sub-module, loaduse_detect, which is purely combinational; the FSM and the counters stay in hazard_ctrl.

Verification
REQ-045 Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> pc_hold=ifid_hold=idex_bubble=1 for one cycle; stall_cnt=1.
REQ-046 Zero destination: ex_memread=1, ex_rt=0, id_rs=0 -> no hold and no bubble.
REQ-047 Memory miss: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> state=1 for 4 cycles with all holds asserted, then state=0.
REQ-048 Simultaneous events: branch_taken=1 with lu and a memory miss -> ifid_flush=idex_bubble=1, state=2 for one cycle, then 0; mem_err stays 0.
REQ-049 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 4 MEM_WAIT cycles, state=0, and mem_err persists.
REQ-050 Reset mid-wait: reset=0 during MEM_WAIT -> all outputs 0 and state=0 without waiting for a clock edge.
